dmem_access_ctrl: RTL and testbench

- Memory-stage controller between the EXE/MEM pipeline register and the 64-word data memory array.
- Translates the ALU byte address into a word index and range-checks it.
- Models a fixed number of wait states and drives a freeze (ready) signal back to the pipeline.
- Registers load data for the MEM/WB stage.

---
 rtl/dmem_access_ctrl_pkg.sv | 34 +++
 rtl/dmem_access_ctrl_wait.sv | 29 ++
 rtl/dmem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_dmem_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: state encoding,
// default geometry/timing, and the byte-address to word-index decoder.
package dmem_access_ctrl_pkg;

  localparam int DEF_ADDR_BASE   = 1024;
  localparam int DEF_DEPTH       = 64;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int IDX_W           = 6;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             invalid;
  } decode_t;

  // The full 32-bit word offset is range-checked before truncating to IDX_W.
  function automatic decode_t addr_decode(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
    logic [31:0] word;
    decode_t     d;
    word      = (addr - base) >> 2;
    d.idx     = word[IDX_W-1:0];
    d.invalid = (addr < base) || (word >= depth) || (addr[1:0] != 2'b00);
    return d;
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_wait.sv
// dmem_wait_counter: loadable down-counter that stops at zero; terminal marks
// the last wait state (count == 1).
import dmem_access_ctrl_pkg::*;

module dmem_wait_counter #(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == W'(1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: decodes/range-checks the ALU address, inserts
// WAIT_CYCLES wait states and freezes the pipeline. Optional last-read hit
// shortcut is enabled by defining DMEM_ACCESS_CTRL_HIT_EN.
import dmem_access_ctrl_pkg::*;

module dmem_access_ctrl #(
  parameter int ADDR_BASE   = DEF_ADDR_BASE,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_r_en,
  input  logic        req_w_en,
  input  logic [31:0] alu_addr,
  input  logic [31:0] st_val,
  output logic        ready,
  output logic [31:0] rd_data,
  output logic        addr_err,
  output logic [5:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  state
);

  // Handshake: ready=1 means the pipeline advances on the next edge; while
  // ready=0 upstream is frozen so request inputs are held and never re-sampled.

  state_t           state_q;
  decode_t          dec;
  logic             req;
  logic             hit;
  logic             accept;
  logic             op_wr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_term;

  assign dec    = addr_decode(alu_addr, 32'(ADDR_BASE), 32'(DEPTH));
  assign req    = req_r_en | req_w_en;
  assign accept = (state_q == IDLE) && req && !dec.invalid && !hit;

  assign ready    = ((state_q == IDLE) && !accept) || (state_q == DONE);
  assign addr_err = (state_q == IDLE) && req && dec.invalid;
  assign state    = state_q;

  dmem_wait_counter #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (CNT_W'(WAIT_CYCLES)),
    .en       (state_q == BUSY),
    .count    (cnt),
    .terminal (cnt_term)
  );

`ifdef DMEM_ACCESS_CTRL_HIT_EN
  logic [IDX_W-1:0] tag_idx;
  logic             tag_valid;

  assign hit = req && !req_w_en && !dec.invalid && tag_valid && (tag_idx == dec.idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_idx   <= '0;
      tag_valid <= 1'b0;
    end else if (accept && req_w_en) begin
      tag_valid <= 1'b0;
    end else if ((state_q == BUSY) && cnt_term && !op_wr) begin
      tag_idx   <= mem_addr;
      tag_valid <= 1'b1;
    end
  end
`else
  assign hit = 1'b0;
`endif

  // Strobes are registered so they are high exactly in the cycle where the
  // counter reads 1; they are armed one edge earlier.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_wr     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      rd_data   <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= BUSY;
            op_wr     <= req_w_en;
            mem_addr  <= dec.idx;
            mem_wdata <= st_val;
            if (WAIT_CYCLES == 1) begin
              mem_we <= req_w_en;
              mem_re <= !req_w_en;
            end
          end
        end
        BUSY: begin
          if (cnt_term) begin
            state_q <= DONE;
            if (!op_wr) rd_data <= mem_rdata;
          end else if (cnt == CNT_W'(2)) begin
            mem_we <= op_wr;
            mem_re <= !op_wr;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 64-word memory array.
// Hit-path checks follow DMEM_ACCESS_CTRL_HIT_EN.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_r_en;
  logic        req_w_en;
  logic [31:0] alu_addr;
  logic [31:0] st_val;
  logic        ready;
  logic [31:0] rd_data;
  logic        addr_err;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;
  logic [1:0]  state;

  logic [31:0] mem [64];
  int          we_count;
  int          re_count;
  logic [5:0]  we_addr_last;
  logic [31:0] we_data_last;

  int total;
  int bad;

  dmem_access_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_r_en  (req_r_en),
    .req_w_en  (req_w_en),
    .alu_addr  (alu_addr),
    .st_val    (st_val),
    .ready     (ready),
    .rd_data   (rd_data),
    .addr_err  (addr_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .state     (state)
  );

  // Clock / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      we_count      = we_count + 1;
      we_addr_last  = mem_addr;
      we_data_last  = mem_wdata;
    end
    if (mem_re) re_count = re_count + 1;
  end

  // Driver: presents one request, returns cycles until ready and addr_err seen.
  task automatic do_access(input logic w, input logic r, input logic [31:0] addr,
                           input logic [31:0] data, output int lat, output logic err);
    req_w_en = w;
    req_r_en = r;
    alu_addr = addr;
    st_val   = data;
    #1;
    err = addr_err;
    lat = 0;
    if (ready) begin
      req_w_en = 1'b0;
      req_r_en = 1'b0;
      @(posedge clk); #1;
    end else begin
      while (!ready && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      req_w_en = 1'b0;
      req_r_en = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_r_en = 1'b0;
    req_w_en = 1'b0;
    alu_addr = 32'd0;
    st_val   = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++;
    if (rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    total++;
    if ({addr_err, mem_we, mem_re} !== 3'b000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=000", {addr_err, mem_we, mem_re});
    end
    total++;
    if ({mem_addr, mem_wdata} !== 38'd0) begin
      bad++; $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store();
    int lat; logic err; int we0;
    we0 = we_count;
    do_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL store_latency got=%0d exp=3", lat); end
    total++;
    if (we_count - we0 !== 1) begin bad++; $display("FAIL store_we_pulses got=%0d exp=1", we_count - we0); end
    total++;
    if (we_addr_last !== 6'd1) begin bad++; $display("FAIL store_we_addr got=%0d exp=1", we_addr_last); end
    total++;
    if (we_data_last !== 32'hDEADBEEF) begin bad++; $display("FAIL store_we_data got=%h exp=deadbeef", we_data_last); end
    total++;
    if (rd_data !== 32'd0) begin bad++; $display("FAIL store_rd_data got=%h exp=0", rd_data); end
  endtask

  task automatic test_load();
    int lat; logic err; int re0;
    re0 = re_count;
    do_access(1'b0, 1'b1, 32'd1028, 32'h0, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL load_latency got=%0d exp=3", lat); end
    total++;
    if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rd_data got=%h exp=deadbeef", rd_data); end
    total++;
    if (re_count - re0 !== 1) begin bad++; $display("FAIL load_re_pulses got=%0d exp=1", re_count - re0); end
    do_access(1'b1, 1'b0, 32'd1032, 32'h12345678, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL store2_latency got=%0d exp=3", lat); end
    total++;
    if (we_addr_last !== 6'd2) begin bad++; $display("FAIL store2_we_addr got=%0d exp=2", we_addr_last); end
    total++;
    if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL store2_rd_kept got=%h exp=deadbeef", rd_data); end
  endtask

  task automatic test_addr_err();
    logic [31:0] bad_addr [3];
    int lat; logic err; int we0; int re0;
    bad_addr[0] = 32'd1000;
    bad_addr[1] = 32'd1030;
    bad_addr[2] = 32'd1280;
    for (int i = 0; i < 3; i++) begin
      we0 = we_count;
      re0 = re_count;
      do_access(1'b0, 1'b1, bad_addr[i], 32'h0, lat, err);
      total++;
      if (err !== 1'b1) begin bad++; $display("FAIL err_pulse addr=%0d got=%b exp=1", bad_addr[i], err); end
      total++;
      if (lat !== 0) begin bad++; $display("FAIL err_ready addr=%0d wait=%0d exp=0", bad_addr[i], lat); end
      total++;
      if ((we_count != we0) || (re_count != re0)) begin
        bad++; $display("FAIL err_no_access addr=%0d we=%0d re=%0d exp=0/0", bad_addr[i], we_count - we0, re_count - re0);
      end
      total++;
      if (addr_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle addr=%0d got=%b exp=0", bad_addr[i], addr_err); end
      total++;
      if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL err_rd_kept addr=%0d got=%h exp=deadbeef", bad_addr[i], rd_data); end
    end
    // Highest legal word.
    do_access(1'b0, 1'b1, 32'd1276, 32'h0, lat, err);
    total++;
    if ((err !== 1'b0) || (lat !== 3)) begin bad++; $display("FAIL top_word err=%b lat=%0d exp=0/3", err, lat); end
    total++;
    if (rd_data !== 32'h3F3F3F3F) begin bad++; $display("FAIL top_word_rd got=%h exp=3f3f3f3f", rd_data); end
  endtask

  task automatic test_both_enables();
    int lat; logic err; int we0; int re0;
    we0 = we_count;
    re0 = re_count;
    do_access(1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL both_latency got=%0d exp=3", lat); end
    total++;
    if ((we_count - we0 !== 1) || (re_count != re0)) begin
      bad++; $display("FAIL both_is_write we=%0d re=%0d exp=1/0", we_count - we0, re_count - re0);
    end
    total++;
    if (mem[4] !== 32'hCAFEF00D) begin bad++; $display("FAIL both_mem got=%h exp=cafef00d", mem[4]); end
    total++;
    if (rd_data !== 32'h3F3F3F3F) begin bad++; $display("FAIL both_rd_kept got=%h exp=3f3f3f3f", rd_data); end
  endtask

  task automatic test_back_to_back();
    int lat1; int lat2; logic err;
    do_access(1'b1, 1'b0, 32'd1048, 32'h0BADCAFE, lat1, err);
    do_access(1'b0, 1'b1, 32'd1048, 32'h0, lat2, err);
    total++;
    if ((lat1 !== 3) || (lat2 !== 3)) begin bad++; $display("FAIL b2b_latency got=%0d/%0d exp=3/3", lat1, lat2); end
    total++;
    if (rd_data !== 32'h0BADCAFE) begin bad++; $display("FAIL b2b_rd_data got=%h exp=0badcafe", rd_data); end
  endtask

  task automatic test_reset_mid_access();
    int we0;
    we0 = we_count;
    req_w_en = 1'b1;
    alu_addr = 32'd1036;
    st_val   = 32'h55AA55AA;
    @(posedge clk); #1;
    rst      = 1'b1;
    req_w_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (state !== 2'd0) begin bad++; $display("FAIL rstmid_state got=%0d exp=0", state); end
    total++;
    if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    total++;
    if (rd_data !== 32'd0) begin bad++; $display("FAIL rstmid_rd_data got=%h exp=0", rd_data); end
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (we_count != we0) begin bad++; $display("FAIL rstmid_no_we got=%0d exp=0", we_count - we0); end
    total++;
    if (mem[3] !== 32'h03030303) begin bad++; $display("FAIL rstmid_mem got=%h exp=03030303", mem[3]); end
  endtask

  task automatic test_hit();
    int lat; logic err; int re0;
    do_access(1'b0, 1'b1, 32'd1044, 32'h0, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL hit_first_latency got=%0d exp=3", lat); end
    total++;
    if (rd_data !== 32'h05050505) begin bad++; $display("FAIL hit_first_rd got=%h exp=05050505", rd_data); end
    re0 = re_count;
    do_access(1'b0, 1'b1, 32'd1044, 32'h0, lat, err);
`ifdef DMEM_ACCESS_CTRL_HIT_EN
    total++;
    if ((lat !== 0) || (re_count != re0)) begin bad++; $display("FAIL hit_second lat=%0d re=%0d exp=0/0", lat, re_count - re0); end
`else
    total++;
    if ((lat !== 3) || (re_count - re0 != 1)) begin bad++; $display("FAIL nohit_second lat=%0d re=%0d exp=3/1", lat, re_count - re0); end
`endif
    total++;
    if (rd_data !== 32'h05050505) begin bad++; $display("FAIL hit_second_rd got=%h exp=05050505", rd_data); end
    do_access(1'b1, 1'b0, 32'd1044, 32'h77778888, lat, err);
    do_access(1'b0, 1'b1, 32'd1044, 32'h0, lat, err);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL hit_after_store_latency got=%0d exp=3", lat); end
    total++;
    if (rd_data !== 32'h77778888) begin bad++; $display("FAIL hit_after_store_rd got=%h exp=77778888", rd_data); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    we_count = 0;
    re_count = 0;
    we_addr_last = '0;
    we_data_last = '0;
    for (int i = 0; i < 64; i++) mem[i] = {4{8'(i)}};
    test_reset();
    test_store();
    test_load();
    test_addr_err();
    test_both_enables();
    test_back_to_back();
    test_reset_mid_access();
    test_hit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
